// File: rtl/mest_pro_run_ctrl_if.sv
// rtl/mest_pro_run_ctrl_if.sv - run controller to mest_pro core handshake bundle
interface mest_pro_run_ctrl_if #(
   parameter int DATA_W = 8
);
   logic              memory_reset;
   logic              start;
   logic [DATA_W-1:0] result;
   logic              valid_result;
   logic              carry;
   logic              zero_flag;
   logic              all_done;

   // controller side: drives core reset/start, observes results
   modport master (
      output memory_reset, start,
      input  result, valid_result, carry, zero_flag, all_done
   );

   // core side
   modport slave (
      input  memory_reset, start,
      output result, valid_result, carry, zero_flag, all_done
   );
endinterface

// File: rtl/mest_pro_run_ctrl.sv
// rtl/mest_pro_run_ctrl.sv - run sequencer with watchdog and result statistics
module mest_pro_run_ctrl #(
   parameter int DATA_W         = 8,
   parameter int MEM_RST_CYCLES = 4,
   parameter int TIMEOUT_W      = 16,
   parameter int CNT_W          = 8
) (
   input  logic                 clk,
   input  logic                 i_reset,
   input  logic                 i_run_req,
   input  logic                 i_abort,
   input  logic [TIMEOUT_W-1:0] i_timeout_limit,
   output logic                 o_busy,
   mest_pro_run_ctrl_if.master  core,
   output logic [CNT_W-1:0]     o_result_count,
   output logic [15:0]          o_checksum,
   output logic [DATA_W-1:0]    o_last_result,
   output logic                 o_last_carry,
   output logic                 o_last_zero,
   output logic                 o_run_done,
   output logic                 o_run_timeout,
   output logic                 o_run_aborted
);

   localparam int MC_W = (MEM_RST_CYCLES > 1) ? $clog2(MEM_RST_CYCLES) : 1;

   typedef enum logic [2:0] {
      IDLE, MEM_RST, START, RUN, DONE, TIMEOUT, ABORT
   } state_t;

   state_t               state;
   logic [MC_W-1:0]      mem_cnt;
   logic [TIMEOUT_W-1:0] limit_q;
   logic [TIMEOUT_W-1:0] wdog;
   logic                 mem_rst_q;
   logic                 start_q;

   assign core.memory_reset = mem_rst_q;
   assign core.start        = start_q;

   // run sequencer: all outputs registered, stats captured only in RUN
   always_ff @(posedge clk) begin
      if (i_reset) begin
         state          <= IDLE;
         mem_cnt        <= '0;
         limit_q        <= '0;
         wdog           <= '0;
         mem_rst_q      <= 1'b0;
         start_q        <= 1'b0;
         o_busy         <= 1'b0;
         o_result_count <= '0;
         o_checksum     <= '0;
         o_last_result  <= '0;
         o_last_carry   <= 1'b0;
         o_last_zero    <= 1'b0;
         o_run_done     <= 1'b0;
         o_run_timeout  <= 1'b0;
         o_run_aborted  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (i_run_req) begin
                  state          <= MEM_RST;
                  o_busy         <= 1'b1;
                  mem_rst_q      <= 1'b1;
                  mem_cnt        <= MC_W'(MEM_RST_CYCLES - 1);
                  limit_q        <= i_timeout_limit;
                  o_result_count <= '0;
                  o_checksum     <= '0;
                  o_last_result  <= '0;
                  o_last_carry   <= 1'b0;
                  o_last_zero    <= 1'b0;
               end
            end
            MEM_RST: begin
               if (i_abort) begin
                  state         <= ABORT;
                  mem_rst_q     <= 1'b0;
                  o_run_aborted <= 1'b1;
               end else if (mem_cnt == '0) begin
                  state     <= START;
                  mem_rst_q <= 1'b0;
                  start_q   <= 1'b1;
               end else begin
                  mem_cnt <= mem_cnt - 1'b1;
               end
            end
            START: begin
               start_q <= 1'b0;
               if (i_abort) begin
                  state         <= ABORT;
                  o_run_aborted <= 1'b1;
               end else begin
                  state <= RUN;
                  wdog  <= limit_q;
               end
            end
            RUN: begin
               // abort wins over everything and freezes the statistics
               if (i_abort) begin
                  state         <= ABORT;
                  o_run_aborted <= 1'b1;
               end else begin
                  if (core.valid_result) begin
                     if (o_result_count != '1)
                        o_result_count <= o_result_count + 1'b1;
                     o_checksum    <= o_checksum + 16'(core.result);
                     o_last_result <= core.result;
                     o_last_carry  <= core.carry;
                     o_last_zero   <= core.zero_flag;
                  end
                  if (core.all_done) begin
                     state      <= DONE;
                     o_run_done <= 1'b1;
                  end else if (limit_q != '0 && wdog == TIMEOUT_W'(1)) begin
                     state         <= TIMEOUT;
                     o_run_timeout <= 1'b1;
                  end else if (limit_q != '0) begin
                     wdog <= wdog - 1'b1;
                  end
               end
            end
            DONE, TIMEOUT, ABORT: begin
               state         <= IDLE;
               o_busy        <= 1'b0;
               o_run_done    <= 1'b0;
               o_run_timeout <= 1'b0;
               o_run_aborted <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
